// File: rtl/gumnut_alu_wb_if.sv
// Signal bundle between the Gumnut ALU/decoder side, the register-file write port and
// the interrupt controller; the writeback stage uses the slave modport.
interface gumnut_alu_wb_if #(
  parameter int DATA_W    = 8,
  parameter int RF_ADDR_W = 3
);
  // Handshake: a transfer happens on a rising edge where alu_valid_i & alu_ready_o;
  // alu_ready_o never depends on alu_valid_i, and the ALU fields are only sampled on a transfer.
  logic                 alu_valid_i;
  logic                 alu_ready_o;
  logic [DATA_W-1:0]    res_i;
  logic                 carry_i;
  logic                 zero_i;
  logic                 ovf_i;
  logic                 nf_i;
  logic [RF_ADDR_W-1:0] rd_i;
  logic                 wb_en_i;
  logic                 upd_flags_i;
  logic                 wb_stall_i;
  logic                 int_enter_i;
  logic                 reti_i;
  logic                 rf_we_o;
  logic [RF_ADDR_W-1:0] rf_waddr_o;
  logic [DATA_W-1:0]    rf_wdata_o;
  logic                 z_o;
  logic                 c_o;
  logic                 v_o;
  logic                 n_o;
  logic                 int_active_o;
  logic                 int_err_o;
  logic                 dbg_buf_full_o;

  modport slave (
    input  alu_valid_i, res_i, carry_i, zero_i, ovf_i, nf_i, rd_i, wb_en_i,
           upd_flags_i, wb_stall_i, int_enter_i, reti_i,
    output alu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, z_o, c_o, v_o, n_o,
           int_active_o, int_err_o, dbg_buf_full_o
  );

  modport master (
    output alu_valid_i, res_i, carry_i, zero_i, ovf_i, nf_i, rd_i, wb_en_i,
           upd_flags_i, wb_stall_i, int_enter_i, reti_i,
    input  alu_ready_o, rf_we_o, rf_waddr_o, rf_wdata_o, z_o, c_o, v_o, n_o,
           int_active_o, int_err_o, dbg_buf_full_o
  );
endinterface

// File: rtl/gumnut_alu_wb.sv
// Gumnut execute-to-writeback stage: 1-entry register-file write buffer, architectural
// Z/C/V/N condition codes, and Z/C save/restore across interrupt entry and reti.
module gumnut_alu_wb #(
  parameter int DATA_W    = 8,
  parameter int RF_ADDR_W = 3
) (
  input logic            clk_i,
  input logic            rst_ni,
  gumnut_alu_wb_if.slave bus
);

  typedef enum logic {BUF_EMPTY = 1'b0, BUF_FULL = 1'b1} buf_state_t;
  typedef enum logic {INT_NORMAL = 1'b0, INT_IN = 1'b1} int_state_t;

  buf_state_t           r_buf_state, w_buf_next;
  int_state_t           r_int_state, w_int_next;
  logic [RF_ADDR_W-1:0] r_waddr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_z, r_c, r_v, r_n;
  logic                 r_sz, r_sc;
  logic                 r_int_err;

  logic w_xfer, w_load, w_upd;
  logic w_z_upd, w_c_upd, w_v_upd, w_n_upd;
  logic w_do_enter, w_do_reti, w_err;

  assign bus.alu_ready_o = (r_buf_state == BUF_EMPTY) | ~bus.wb_stall_i;
  assign w_xfer          = bus.alu_valid_i & bus.alu_ready_o;
  // r0 is hardwired zero, so writes to it never occupy the buffer.
  assign w_load          = w_xfer & bus.wb_en_i & (bus.rd_i != '0);
  assign w_upd           = w_xfer & bus.upd_flags_i;

  assign w_z_upd = w_upd ? bus.zero_i  : r_z;
  assign w_c_upd = w_upd ? bus.carry_i : r_c;
  assign w_v_upd = w_upd ? bus.ovf_i   : r_v;
  assign w_n_upd = w_upd ? bus.nf_i    : r_n;

  // A simultaneous int_enter/reti pair is always illegal; only the reti half is honoured.
  assign w_do_reti  = bus.reti_i & (r_int_state == INT_IN);
  assign w_do_enter = bus.int_enter_i & ~bus.reti_i & (r_int_state == INT_NORMAL);
  assign w_err      = (bus.int_enter_i & bus.reti_i)
                    | (bus.int_enter_i & (r_int_state == INT_IN))
                    | (bus.reti_i & (r_int_state == INT_NORMAL));

  always_comb begin
    w_buf_next = r_buf_state;
    w_int_next = r_int_state;
    case (r_buf_state)
      BUF_EMPTY: if (w_load) w_buf_next = BUF_FULL;
      BUF_FULL:  if (~bus.wb_stall_i && ~w_load) w_buf_next = BUF_EMPTY;
      default:   w_buf_next = BUF_EMPTY;
    endcase
    case (r_int_state)
      INT_NORMAL: if (w_do_enter) w_int_next = INT_IN;
      INT_IN:     if (w_do_reti) w_int_next = INT_NORMAL;
      default:    w_int_next = INT_NORMAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_buf_state <= BUF_EMPTY;
      r_int_state <= INT_NORMAL;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_n         <= 1'b0;
      r_sz        <= 1'b0;
      r_sc        <= 1'b0;
      r_int_err   <= 1'b0;
    end else begin
      r_buf_state <= w_buf_next;
      r_int_state <= w_int_next;
      if (w_load) begin
        r_waddr <= bus.rd_i;
        r_wdata <= bus.res_i;
      end
      r_v <= w_v_upd;
      r_n <= w_n_upd;
      // Restore beats a same-cycle update for Z/C; entry saves the post-update Z/C.
      if (w_do_reti) begin
        r_z <= r_sz;
        r_c <= r_sc;
      end else begin
        r_z <= w_z_upd;
        r_c <= w_c_upd;
      end
      if (w_do_enter) begin
        r_sz <= w_z_upd;
        r_sc <= w_c_upd;
      end
      r_int_err <= w_err;
    end
  end

  assign bus.rf_we_o        = (r_buf_state == BUF_FULL) & ~bus.wb_stall_i;
  assign bus.rf_waddr_o     = r_waddr;
  assign bus.rf_wdata_o     = r_wdata;
  assign bus.z_o            = r_z;
  assign bus.c_o            = r_c;
  assign bus.v_o            = r_v;
  assign bus.n_o            = r_n;
  assign bus.int_active_o   = (r_int_state == INT_IN);
  assign bus.int_err_o      = r_int_err;
  assign bus.dbg_buf_full_o = (r_buf_state == BUF_FULL);

endmodule
